// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core
//   Multi-cycle RISC-V core for a reduced RV32I/RV32E subset: ADDI, ADD, SUB,
//   BEQ and BNE. Each instruction takes four cycles: FETCH, DECODE, EXECUTE and
//   WRITEBACK. Any illegal condition parks the core in HALT until the next reset.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   FETCH     | present PC on imem_addr
//   DECODE    | capture imem_rdata into IR
//   EXECUTE   | decode IR, register the ALU result, branch-taken flag and target
//   WRITEBACK | write rd, update PC, pulse retire
//   HALT      | absorbing after an illegal condition; halted=1
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         the FSM advances only when this is 1
//   imem_addr  instruction byte address (always equal to PC)
//   imem_rdata instruction word, valid one cycle after imem_addr is presented
//   a0         continuous view of register x10
//   retire     one-cycle pulse when an instruction completes
//   halted     sticky illegal-condition flag, cleared only by rst
module rv_multicycle_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic [DATA_WIDTH-1:0] a0,
  output logic                  retire,
  output logic                  halted
);

  localparam int IW = $clog2(NUM_REGS);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_WRITEBACK = 3'd3;
  localparam logic [2:0] S_HALT      = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] alu_q;
  logic                  taken_q;
  logic [ADDR_WIDTH-1:0] target_q;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  logic                  is_addi, is_add, is_sub, is_beq, is_bne;
  logic                  writes_rd, uses_rs2, known;
  logic                  rs1_ok, rs2_ok, rd_ok;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val, imm_i, alu;
  logic signed [12:0]    imm_b;
  logic [ADDR_WIDTH-1:0] target;
  logic                  taken, exec_halt;

  always_comb begin
    is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
    is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    is_sub    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    is_beq    = (opcode == 7'b1100011) && (funct3 == 3'b000);
    is_bne    = (opcode == 7'b1100011) && (funct3 == 3'b001);
    writes_rd = is_addi | is_add | is_sub;
    uses_rs2  = is_add | is_sub | is_beq | is_bne;
    known     = writes_rd | is_beq | is_bne;

    // Widened compare so RV32I (every 5-bit index legal) and RV32E share one form.
    rs1_ok = ({27'd0, rs1} < 32'(NUM_REGS));
    rs2_ok = ({27'd0, rs2} < 32'(NUM_REGS));
    rd_ok  = ({27'd0, rd}  < 32'(NUM_REGS));

    rs1_val = '0;
    rs2_val = '0;
    if (rs1_ok && rs1 != 5'd0) rs1_val = regs[rs1[IW-1:0]];
    if (rs2_ok && rs2 != 5'd0) rs2_val = regs[rs2[IW-1:0]];

    // Signed size casts sign-extend (or truncate when ADDR_WIDTH < 13).
    imm_i  = DATA_WIDTH'($signed(ir[31:20]));
    imm_b  = $signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
    target = pc + ADDR_WIDTH'(imm_b);

    if (is_addi)     alu = rs1_val + imm_i;
    else if (is_sub) alu = rs1_val - rs2_val;
    else             alu = rs1_val + rs2_val;

    taken     = (is_beq && (rs1_val == rs2_val)) || (is_bne && (rs1_val != rs2_val));
    exec_halt = !known || !rs1_ok || (uses_rs2 && !rs2_ok) || (writes_rd && !rd_ok)
                || (taken && target[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      alu_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (en) begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          ir    <= imem_rdata;
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          alu_q    <= alu;
          taken_q  <= taken;
          target_q <= target;
          state    <= exec_halt ? S_HALT : S_WRITEBACK;
        end
        S_WRITEBACK: begin
          // IR is still stable here, so the decode flags remain valid.
          if (writes_rd && rd != 5'd0) regs[rd[IW-1:0]] <= alu_q;
          pc    <= taken_q ? target_q : pc + ADDR_WIDTH'(4);
          state <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign imem_addr = pc;
  assign a0        = regs[10];
  assign retire    = (state == S_WRITEBACK) && en && !rst;
  assign halted    = (state == S_HALT);

endmodule

// File: doc/rv_multicycle_core.md
Name: rv_multicycle_core

Overview:
- Parametrised multi-cycle successor to the Lab 4 reduced RISC-V top level.
- Fetches 32-bit instructions from an external synchronous instruction memory and executes a reduced RV32I/RV32E subset: ADDI, ADD, SUB, BEQ, BNE.
- Uses a 4-state FSM and exposes register a0 (x10) for observation.
- Adds stall (en), illegal-instruction halt, configurable register count and retire pulse.

Parameters:
- DATA_WIDTH, 32, register/ALU width; legal range 16..64; immediates sign-extended to DATA_WIDTH.
- ADDR_WIDTH, 16, PC and imem_addr width in bytes; PC wraps modulo 2^ADDR_WIDTH.
- NUM_REGS, 32, architectural register count; 32 (RV32I) or 16 (RV32E).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, FSM advances only when 1; holds all state when 0.
- imem_addr, output, ADDR_WIDTH, byte address; equals PC.
- imem_rdata, input, 32, instruction word, valid one cycle after imem_addr is presented.
- a0, output, DATA_WIDTH, continuous view of x10.
- retire, output, 1, one-cycle pulse when an instruction completes.
- halted, output, 1, high once an illegal condition is hit; sticky until rst.

Behaviour:
- Reset (rst=1 at posedge):
  - PC=0, all registers 0, state=FETCH, IR=0.
  - retire=0, halted=0, so a0=0.
  - Reset overrides en and any in-flight instruction.
- States (each transition requires en=1; with en=0 state, PC, IR and regs hold and retire=0):
  - FETCH: imem_addr=PC. -> DECODE.
  - DECODE: IR<=imem_rdata; rs1/rs2 operands read combinationally from IR next cycle. -> EXECUTE.
  - EXECUTE: decode IR, compute ALU result / branch condition into registered ALUResult and branch-taken flag. Illegal -> HALT, else -> WRITEBACK.
  - WRITEBACK: write rd if the instruction writes; update PC; retire=1 this cycle only. -> FETCH.
  - HALT: absorbing; halted=1; no register or PC writes; retire=0.
- CPI is exactly 4 with en held high; first retire pulse is in the 4th cycle after rst deassert.
- Decode:
  - ADDI: opcode 0010011, funct3 000; rd=rs1+sext(imm[11:0]).
  - ADD/SUB: opcode 0110011, funct3 000, funct7 0000000 / 0100000.
  - BEQ/BNE: opcode 1100011, funct3 000 / 001; target=PC+sext(B-imm, 13 bits).
  - Any other encoding is illegal -> HALT.
- Arithmetic is modulo 2^DATA_WIDTH; no overflow flag. Equality compares the full DATA_WIDTH.
- PC update: PC+4, or the branch target if taken; wraps modulo 2^ADDR_WIDTH.
- Taken branch whose target has bit1 set (misaligned) -> HALT from EXECUTE; PC unchanged, no retire.
- Register rules:
  - Any rs1/rs2/rd index >= NUM_REGS -> HALT.
  - Writes to x0 are discarded; x0 always reads 0.
- a0 updates the cycle after WRITEBACK with rd=10. With NUM_REGS=16, x10 still exists.

Test Plan:
- Reset/stall: rst 2 cycles, imem returns ADDI x10,x0,5 (0x00500513); hold en=0 for 10 cycles -> a0=0, retire never pulses. Raise en -> retire in 4th cycle, then a0=5, imem_addr=4.
- Arithmetic sequence, with the check after each retire:
  - ADDI x1,x0,-1 -> x1=0xFFFFFFFF.
  - ADDI x2,x0,3.
  - ADD x10,x1,x2 -> a0=2 (wrap).
  - SUB x10,x0,x2 -> a0=0xFFFFFFFD.
  - ADDI x0,x0,7 -> x0 stays 0 (then ADD x10,x0,x0 -> a0=0).
- Branch loop: x10=0, x5=3; body ADDI x10,x10,1; BNE x10,x5,-4 -> exactly 3 taken/not-taken evaluations, a0=3, final imem_addr = loop exit address; BEQ x0,x0,+8 skips one instruction.
- Illegal: feed 0x00000073 (ECALL) -> halted=1 in the cycle after EXECUTE, no retire, PC frozen; en toggling has no effect; rst clears halted and PC=0.
- RV32E (NUM_REGS=16): ADDI x16,x0,1 -> halted=1, registers unchanged; ADDI x10,x0,9 before it -> a0=9 retained.
- Mid-instruction reset and wrap: assert rst during EXECUTE of ADDI x10,x0,5 -> a0 stays 0, state FETCH, PC=0. With ADDR_WIDTH=4, PC=12 executing ADDI -> next imem_addr=0.
